// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for an external 8-bit combinational ALU: queues commands,
// registers the ALU operands, captures result/flags and returns them on a valid/ready port.
module alu_cmd_sequencer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [7:0]                  cmd_a,
    input  logic [7:0]                  cmd_b,
    input  logic [1:0]                  cmd_sel,
    input  logic                        cmd_acc,
    output logic [7:0]                  alu_a,
    output logic [7:0]                  alu_b,
    output logic [1:0]                  alu_sel,
    input  logic [7:0]                  alu_out,
    input  logic                        alu_carry,
    input  logic                        alu_zero,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [7:0]                  rsp_data,
    output logic                        rsp_carry,
    output logic                        rsp_zero,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 19;
    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [EW-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q, level_d;
    logic [1:0]    state_q, state_d;

    logic [7:0] alu_a_q, alu_a_d;
    logic [7:0] alu_b_q, alu_b_d;
    logic [1:0] alu_sel_q, alu_sel_d;
    logic [7:0] acc_q, acc_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic       rsp_carry_q, rsp_carry_d;
    logic       rsp_zero_q, rsp_zero_d;

    logic          push, pop, fifo_empty, capture;
    logic [EW-1:0] head;
    logic [7:0]    head_a, head_b;
    logic [1:0]    head_sel;
    logic          head_acc;

    assign cmd_ready  = (level_q != LVL_FULL);
    assign fifo_empty = (level_q == '0);
    assign push       = cmd_valid && cmd_ready;
    assign head       = fifo_mem[rd_ptr_q];
    assign {head_a, head_b, head_sel, head_acc} = head;
    assign capture    = (state_q == ST_EXEC);

    // Only the FSM pops; a pop always coincides with loading the ALU operand registers.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = ST_EXEC;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    // acc is written at capture, before the next pop can happen, so it is always current here.
    always_comb begin
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        acc_d       = acc_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_carry_d = rsp_carry_q;
        rsp_zero_d  = rsp_zero_q;
        if (pop) begin
            alu_a_d   = head_acc ? acc_q : head_a;
            alu_b_d   = head_b;
            alu_sel_d = head_sel;
        end
        if (capture) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = alu_out;
            rsp_carry_d = alu_carry;
            rsp_zero_d  = alu_zero;
            acc_d       = alu_out;
        end else if ((state_q == ST_RESP) && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {cmd_a, cmd_b, cmd_sel, cmd_acc};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            acc_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_carry_q <= 1'b0;
            rsp_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            acc_q       <= acc_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_zero_q  <= rsp_zero_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_sel    = alu_sel_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_carry  = rsp_carry_q;
    assign rsp_zero   = rsp_zero_q;
    assign fifo_level = level_q;

endmodule
